// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one 5-bit pulse channel among NUM_REQ buffered sources.
// Each granted pulse lasts 1 or 2 cycles and is followed by one all-zero cycle.
module pulse_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [5*NUM_REQ-1:0]       req_pulse,
    input  logic                       hold_two,
    input  logic                       clear_ovf,
    output logic [4:0]                 out_pulse,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         overflow
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    state_t state, state_next;

    logic [3:0]    mem    [NUM_REQ][DEPTH];
    logic [AW-1:0] wr_ptr [NUM_REQ];
    logic [AW-1:0] rd_ptr [NUM_REQ];
    logic [AW:0]   cnt    [NUM_REQ];

    logic [NUM_REQ-1:0] push, pop, accept, drop, nonempty;
    logic [SW-1:0]      last_grant, grant_idx, src_next, last_next;
    logic [4:0]         out_next;
    logic               any_pending, grant, hold_q, hold_next;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            nonempty[i] = (cnt[i] != '0);
        end
    end

    // A push into a full FIFO survives only when the same FIFO is popped this cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]   = req_pulse[5*i+4];
            pop[i]    = grant && (grant_idx == SW'(i));
            accept[i] = push[i] && ((cnt[i] != (AW+1)'(DEPTH)) || pop[i]);
            drop[i]   = push[i] && !accept[i];
        end
    end

    // Scan downward so the closest source after last_grant is the one left selected.
    always_comb begin
        any_pending = 1'b0;
        grant_idx   = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (nonempty[SW'((int'(last_grant) + k) % NUM_REQ)]) begin
                any_pending = 1'b1;
                grant_idx   = SW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_next = state;
        out_next   = out_pulse;
        src_next   = out_src;
        hold_next  = hold_q;
        last_next  = last_grant;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                out_next = '0;
                if (any_pending) begin
                    grant      = 1'b1;
                    out_next   = {1'b1, mem[grant_idx][rd_ptr[grant_idx]]};
                    src_next   = grant_idx;
                    hold_next  = hold_two;
                    last_next  = grant_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (hold_q) begin
                    state_next = HOLD;
                end else begin
                    out_next   = '0;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                out_next   = '0;
                state_next = IDLE;
            end
            default: begin
                out_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_pulse  <= '0;
            out_src    <= '0;
            hold_q     <= 1'b0;
            last_grant <= SW'(NUM_REQ - 1);
            overflow   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            out_pulse  <= out_next;
            out_src    <= src_next;
            hold_q     <= hold_next;
            last_grant <= last_next;
            // A fresh drop outranks a simultaneous clear.
            overflow   <= (clear_ovf ? '0 : overflow) | drop;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                cnt[i] <= cnt[i] + (AW+1)'(accept[i]) - (AW+1)'(pop[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) mem[i][wr_ptr[i]] <= req_pulse[5*i +: 4];
        end
    end

    assign busy = (state != IDLE) || (|nonempty);

endmodule

// File: tb/tb_pulse_arbiter.sv
// Bench for pulse_arbiter: directed steps plus random traffic against a queue-based reference model.
module tb_pulse_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] req_pulse = '0;
    logic        hold_two  = 1'b0;
    logic        clear_ovf = 1'b0;
    logic [4:0]  out_pulse;
    logic [1:0]  out_src;
    logic        busy;
    logic [3:0]  overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-source queues, a pulse countdown and the last granted source.
    logic [3:0] q [NUM_REQ][$];
    int         phase;
    int         m_last;
    logic [4:0] exp_out;
    logic [1:0] exp_src;
    logic [3:0] exp_ovf;

    pulse_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .req_pulse(req_pulse), .hold_two(hold_two),
        .clear_ovf(clear_ovf), .out_pulse(out_pulse), .out_src(out_src),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] mk(input int src, input logic [3:0] payload);
        logic [19:0] v;
        v = '0;
        v[5*src +: 5] = {1'b1, payload};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NUM_REQ; s++) q[s].delete();
        phase   = 0;
        m_last  = NUM_REQ - 1;
        exp_out = '0;
        exp_src = '0;
        exp_ovf = '0;
    endtask

    task automatic model_edge(input logic [19:0] req, input logic hold, input logic clr);
        int pick;
        int s;
        logic [3:0] drops;
        drops = '0;
        pick  = -1;
        if (phase == 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                s = (m_last + k) % NUM_REQ;
                if (pick < 0 && q[s].size() > 0) pick = s;
            end
            if (pick >= 0) begin
                exp_out = {1'b1, q[pick].pop_front()};
                exp_src = 2'(pick);
                m_last  = pick;
                phase   = hold ? 2 : 1;
            end else begin
                exp_out = '0;
            end
        end else begin
            phase--;
            if (phase == 0) exp_out = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[5*i+4]) begin
                if (q[i].size() < DEPTH) q[i].push_back(req[5*i +: 4]);
                else drops[i] = 1'b1;
            end
        end
        exp_ovf = (clr ? 4'b0 : exp_ovf) | drops;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_busy;
        exp_busy = (phase != 0);
        for (int s = 0; s < NUM_REQ; s++) if (q[s].size() > 0) exp_busy = 1'b1;
        chk({tag, ".out_pulse"}, {3'b000, out_pulse}, {3'b000, exp_out});
        chk({tag, ".out_src"},   {6'b0, out_src},     {6'b0, exp_src});
        chk({tag, ".busy"},      {7'b0, busy},        {7'b0, exp_busy});
        chk({tag, ".overflow"},  {4'b0, overflow},    {4'b0, exp_ovf});
    endtask

    task automatic step(input string tag, input logic [19:0] req, input logic hold, input logic clr);
        req_pulse = req;
        hold_two  = hold;
        clear_ovf = clr;
        @(posedge clock);
        model_edge(req, hold, clr);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        req_pulse = '0;
        hold_two  = 1'b0;
        clear_ovf = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [19:0] r;
        logic        prev_on;
        logic [1:0]  prev_src;
        logic        have_prev;

        #2;
        do_reset("reset0");
        chk("reset0.out_zero", {3'b000, out_pulse}, 8'h00);

        // Single request from source 2, 1-cycle pulse.
        step("single.req", mk(2, 4'b0110), 1'b0, 1'b0);
        step("single.wait", '0, 1'b0, 1'b0);
        chk("single.pulse", {3'b000, out_pulse}, 8'b0001_0110);
        chk("single.src", {6'b0, out_src}, 8'd2);
        step("single.gap", '0, 1'b0, 1'b0);
        chk("single.busy_low", {7'b0, busy}, 8'd0);
        step("single.idle", '0, 1'b0, 1'b0);

        // Simultaneous requests from all sources, served 0..3.
        do_reset("reset1");
        step("simul.req", mk(0, 4'd1) | mk(1, 4'd2) | mk(2, 4'd3) | mk(3, 4'd4), 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) step("simul.drain", '0, 1'b0, 1'b0);

        // Hold mode, hold_two toggled while the pulse is out.
        step("hold.req", mk(1, 4'b1111), 1'b1, 1'b0);
        step("hold.grant", '0, 1'b1, 1'b0);
        chk("hold.pulse1", {3'b000, out_pulse}, 8'b0001_1111);
        step("hold.cyc2", '0, 1'b0, 1'b0);
        chk("hold.pulse2", {3'b000, out_pulse}, 8'b0001_1111);
        step("hold.end", '0, 1'b1, 1'b0);
        chk("hold.cleared", {3'b000, out_pulse}, 8'h00);
        step("hold.idle", '0, 1'b0, 1'b0);

        // Overflow on source 3 while the arbiter is tied up with other sources.
        do_reset("reset2");
        step("ovf.pre", mk(0, 4'd5) | mk(1, 4'd6) | mk(2, 4'd7), 1'b1, 1'b0);
        step("ovf.a", mk(3, 4'hA), 1'b1, 1'b0);
        step("ovf.b", mk(3, 4'hB), 1'b1, 1'b0);
        step("ovf.c", mk(3, 4'hC), 1'b1, 1'b0);
        chk("ovf.flag", {4'b0, overflow}, 8'b0000_1000);
        for (int c = 0; c < 14; c++) step("ovf.drain", '0, 1'b0, 1'b0);
        chk("ovf.sticky", {4'b0, overflow}, 8'b0000_1000);
        step("ovf.clear", '0, 1'b0, 1'b1);
        chk("ovf.cleared", {4'b0, overflow}, 8'h00);

        // Fairness: sources 0 and 1 push every cycle.
        prev_on   = 1'b0;
        have_prev = 1'b0;
        prev_src  = '0;
        for (int c = 0; c < 24; c++) begin
            r = mk(0, 4'($urandom)) | mk(1, 4'($urandom));
            step("rr", r, 1'($urandom), 1'b0);
            if (out_pulse[4] && !prev_on) begin
                if (have_prev) chk("rr.alternate", {7'b0, out_src != prev_src}, 8'd1);
                prev_src  = out_src;
                have_prev = 1'b1;
            end
            prev_on = out_pulse[4];
        end
        for (int c = 0; c < 12; c++) step("rr.drain", '0, 1'b0, 1'b1);

        // Reset during a HOLD cycle with two entries still buffered.
        step("rst.req", mk(0, 4'd8) | mk(1, 4'd9) | mk(2, 4'd10), 1'b1, 1'b0);
        step("rst.grant", '0, 1'b1, 1'b0);
        step("rst.hold", '0, 1'b0, 1'b0);
        chk("rst.pulse_on", {7'b0, out_pulse[4]}, 8'd1);
        do_reset("rst.mid");
        chk("rst.out_zero", {3'b000, out_pulse}, 8'h00);
        for (int c = 0; c < 4; c++) step("rst.quiet", '0, 1'b0, 1'b0);
        step("rst.single", mk(3, 4'd3), 1'b0, 1'b0);
        step("rst.wait", '0, 1'b0, 1'b0);
        chk("rst.single_pulse", {3'b000, out_pulse}, 8'b0001_0011);
        chk("rst.single_src", {6'b0, out_src}, 8'd3);
        step("rst.gap", '0, 1'b0, 1'b0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            r = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 3) == 0) r = r | mk(i, 4'($urandom));
            end
            step("rand", r, 1'($urandom), ($urandom_range(0, 15) == 0));
        end
        for (int c = 0; c < 30; c++) step("rand.drain", '0, 1'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_arbiter.md
# pulse_arbiter

Shares one 5-bit pulse output channel between NUM_REQ independent pulse sources. Each source emits 1-cycle pulses (bit 4 = enable, bits 3:0 = payload), which are buffered per source and issued one at a time in round-robin order. Each issued pulse lasts 1 or 2 cycles, selectable per pulse, and is always followed by at least one all-zero cycle. Sits between the pulse generators and the downstream pulse consumer, replacing direct single-source pulse repetition.

## Interface
- NUM_REQ, 4, number of requesting sources (2..8)
- DEPTH, 2, per-source buffer depth in entries (power of two, ≥2)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_pulse  input  5*NUM_REQ  slice i = bits [5i+4:5i]; bit 4 is enable, bits 3:0 are payload
- hold_two  input  1  1 = issue the next granted pulse for 2 cycles, 0 = 1 cycle
- clear_ovf  input  1  clears all overflow flags
- out_pulse  output  5  issued pulse {1'b1, payload} or 5'b0
- out_src  output  clog2(NUM_REQ)  source index of the current or last issued pulse
- busy  output  1  state ≠ IDLE, or any buffer non-empty
- overflow  output  NUM_REQ  sticky per-source drop flag

Clocking and reset are fixed: one clock; reset is asynchronous and active-high.

## Operation
- Capture: in any cycle where slice i has bit 4 = 1, push payload[3:0] into FIFO i. If bit 4 = 0, the slice is ignored, whatever its payload bits.
- All NUM_REQ slices may push in the same cycle.
- Full FIFO i with a push:
  - If FIFO i is also popped that cycle, the push is accepted.
  - Otherwise the push is dropped and overflow[i] is set.
- overflow: clear_ovf zeroes all bits. If a new drop and clear_ovf occur in the same cycle, the set wins for that bit.
- FSM has three states: IDLE, ISSUE, HOLD.
  - IDLE: out_pulse = 0. If any FIFO is non-empty, grant the first non-empty source searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - IDLE grant actions: pop that FIFO, load out_pulse = {1, payload} and out_src = i, latch hold_two into hold_q, set last_grant = i, and go to ISSUE.
  - IDLE with no pending request: stay in IDLE.
  - ISSUE: out_pulse holds its value. If hold_q = 1, go to HOLD. Otherwise clear out_pulse to 0 and go to IDLE.
  - HOLD: out_pulse holds for one more cycle, then clears to 0 and goes to IDLE.
- out_src keeps the last granted index while in IDLE.
- Reset state: all FIFOs empty, out_pulse = 0, out_src = 0, overflow = 0, state = IDLE, hold_q = 0, last_grant = NUM_REQ-1 (so source 0 wins first), busy = 0.
- Reset asserted mid-pulse aborts the pulse: out_pulse reads 0 immediately, and buffered entries are discarded.

## Timing
- Request with bit 4 high in cycle t → entry written at the edge ending t → visible as pending in t+1.
- If IDLE in t+1: grant at the edge ending t+1, so out_pulse is valid in cycle t+2. Minimum latency is 2 cycles.
- Pulse length: 1 cycle (hold_q = 0) or 2 cycles (hold_q = 1). Exactly 1 zero cycle follows, during which the next grant is made.
- Back-to-back throughput: one pulse every 2 cycles (hold 0) or every 3 cycles (hold 1).
- hold_two is sampled only in the IDLE cycle that grants. Changes while in ISSUE or HOLD do not affect the current pulse.
- Each FIFO serves its entries in arrival order.
- Round-robin guarantee: with all sources continuously pending, every source is granted once per NUM_REQ grants.
- busy deasserts in the IDLE cycle after the last pulse, once all FIFOs are empty.

## Test plan
- Single request: reset, then slice 2 = 5'b10110 for 1 cycle with hold_two = 0 → out_pulse = 5'b10110 two cycles later for exactly 1 cycle, out_src = 2, then 0; busy falls after.
- Simultaneous requests: slices 0..3 pulse in the same cycle with payloads 1, 2, 3, 4 → pulses issue in order src 0, 1, 2, 3 with payloads 1..4, one every 2 cycles, each separated by a zero cycle.
- Hold mode: hold_two = 1, slice 1 = 5'b11111 → out_pulse = 5'b11111 for 2 consecutive cycles, then 0. Toggling hold_two mid-pulse changes nothing.
- Overflow: 3 pulses to slice 3 in 3 consecutive cycles while source 3 has not been granted → third payload dropped, overflow = 4'b1000, first two payloads issued in order. Then clear_ovf → overflow = 0.
- Round-robin fairness: keep slices 0 and 1 pushing continuously → grants alternate 0, 1, 0, 1…; no source is granted twice in a row while the other is pending.
- Reset mid-operation: assert reset during a HOLD cycle with 2 entries buffered → out_pulse = 0 immediately. After release: no pulses, busy = 0, and the next single request issues from its own source with 2-cycle latency.
